// File: rtl/fact_pkg.sv
// Shared types and constants for the factorial accelerator control unit
// and datapath.
package fact_pkg;

  // Control unit state encoding; values 6 and 7 are unused.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    MULT  = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  // Largest n whose factorial fits in 32 bits; the datapath raises gt_in above it.
  localparam int unsigned FACT_MAX_N = 12;

endpackage : fact_pkg

// File: rtl/fact_cu_if.sv
// Handshake and datapath-control bundle for fact_cu.
// master: the requester plus the datapath status flags it feeds back.
// slave : the control unit.
interface fact_cu_if;

  logic go;
  logic done;
  logic err;
  logic busy;
  logic gt_in;
  logic gt_fact;
  logic load_cnt;
  logic en;
  logic sel_1;
  logic load_reg;
  logic sel_2;

  modport master (
    output go, gt_in, gt_fact,
    input  done, err, busy, load_cnt, en, sel_1, load_reg, sel_2
  );

  modport slave (
    input  go, gt_in, gt_fact,
    output done, err, busy, load_cnt, en, sel_1, load_reg, sel_2
  );

endinterface : fact_cu_if

// File: rtl/fact_cyc_cnt.sv
// Saturating cycle counter with synchronous clear and count enable.
// Only compiled when FACT_CU_CYCLE_CNT_EN is defined.
`ifdef FACT_CU_CYCLE_CNT_EN
module fact_cyc_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Clear wins over enable; counting stops at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule : fact_cyc_cnt
`endif

// File: rtl/fact_cu.sv
// Factorial control unit: Moore FSM sequencing the factorial datapath and
// serving a four-phase go/done/err handshake.
// Optional feature macro: FACT_CU_CYCLE_CNT_EN adds the CYC_W-bit 'cycles'
// port counting edges spent in LOAD/CHECK/MULT.
module fact_cu
  import fact_pkg::*;
`ifdef FACT_CU_CYCLE_CNT_EN
#(
  parameter int unsigned CYC_W = 8
)
`endif
(
  input  logic           clk,
  input  logic           rst,
`ifdef FACT_CU_CYCLE_CNT_EN
  output logic [CYC_W-1:0] cycles,
`endif
  fact_cu_if.slave       bus
);

  state_t state;
  state_t state_nxt;

  // State register, forced to IDLE while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; gt_in only matters when a request is accepted.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (bus.go && bus.gt_in) begin
          state_nxt = ERR;
        end else if (bus.go) begin
          state_nxt = LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      LOAD:    state_nxt = CHECK;
      CHECK:   state_nxt = bus.gt_fact ? MULT : DONE;
      MULT:    state_nxt = CHECK;
      DONE:    state_nxt = bus.go ? DONE : IDLE;
      ERR:     state_nxt = bus.go ? ERR : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore output decode straight from the state register.
  always_comb begin
    bus.load_cnt = 1'b0;
    bus.en       = 1'b0;
    bus.sel_1    = 1'b0;
    bus.load_reg = 1'b0;
    bus.sel_2    = 1'b0;
    bus.done     = 1'b0;
    bus.err      = 1'b0;
    bus.busy     = 1'b0;
    case (state)
      LOAD: begin
        bus.load_cnt = 1'b1;
        bus.load_reg = 1'b1;
        bus.busy     = 1'b1;
      end
      CHECK: begin
        bus.busy = 1'b1;
      end
      MULT: begin
        bus.sel_1    = 1'b1;
        bus.load_reg = 1'b1;
        bus.en       = 1'b1;
        bus.busy     = 1'b1;
      end
      DONE: begin
        bus.sel_2 = 1'b1;
        bus.done  = 1'b1;
      end
      ERR: begin
        bus.err = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef FACT_CU_CYCLE_CNT_EN
  // Cleared on the edge that accepts a valid request, so an ERR request
  // leaves the previous run's count in place.
  logic cyc_clr;
  assign cyc_clr = (state == IDLE) && bus.go && !bus.gt_in;

  fact_cyc_cnt #(
    .W (CYC_W)
  ) u_cyc_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr   (cyc_clr),
    .en    (bus.busy),
    .count (cycles)
  );
`endif

endmodule : fact_cu

// File: doc/fact_cu.md
Name: fact_cu

Overview:
Control unit that drives the factorial datapath's control interface (load_cnt, en, sel_1, load_reg, sel_2) and consumes its status flags (gt_in, gt_fact). It provides a four-phase go/done/err handshake to the requesting master (SoC register block). It is a Moore FSM with all outputs decoded from the state register. It pairs 1:1 with the factorial datapath inside the factorial accelerator top.

Parameters:
CYC_W, 8, width of the optional cycle counter output (used only with FACT_CU_CYCLE_CNT_EN).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset; state forced to IDLE while low.
go  in  1  request from master; level-sensitive, four-phase handshake.
gt_in  in  1  datapath flag: input n > 12 (overflow for 32-bit).
gt_fact  in  1  datapath flag: internal down-count > 1.
load_cnt  out  1  load the datapath down-counter with n.
en  out  1  decrement the datapath down-counter.
sel_1  out  1  product mux: 0 selects constant 1, 1 selects product*count.
load_reg  out  1  product register write enable.
sel_2  out  1  result gate: 1 drives the product onto nf, 0 drives 0.
done  out  1  result valid; held until go falls.
err  out  1  input out of range; held until go falls.
busy  out  1  high in LOAD, CHECK and MULT.
cycles  out  CYC_W  present only with FACT_CU_CYCLE_CNT_EN.

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0. cycles=0.
- States and Moore outputs (any output not listed is 0):
  - IDLE: all 0. go=1 and gt_in=1 -> ERR. go=1 and gt_in=0 -> LOAD. Otherwise stay.
  - LOAD: load_cnt=1, load_reg=1, sel_1=0, busy=1. Counter<=n, product<=1. Always -> CHECK.
  - CHECK: busy=1. gt_fact=1 -> MULT, else -> DONE.
  - MULT: sel_1=1, load_reg=1, en=1, busy=1. Product<=product*count, count<=count-1. Always -> CHECK.
  - DONE: sel_2=1, done=1. go=1 -> stay, go=0 -> IDLE.
  - ERR: err=1. go=1 -> stay, go=0 -> IDLE.
- gt_in is sampled only in IDLE with go=1. n must remain stable while go is high; this is a master obligation and is not checked.
- Latency: done rises 2*max(n,1) clock edges after the edge that samples go=1 in IDLE. Examples: n=0 -> 2, n=1 -> 2, n=5 -> 10, n=12 -> 24. err rises 1 edge after sampling.
- go falling during LOAD/CHECK/MULT is ignored. The computation completes, DONE is entered, done is high for exactly one cycle, then IDLE.
- go held high after DONE/ERR: the output holds indefinitely. No new computation starts until go has been low for at least one cycle (IDLE reached).
- load_cnt and en are never high in the same cycle. sel_2=1 only in DONE.
- Reset asserted mid-operation: immediate return to IDLE, outputs 0. Datapath register contents are don't-care; the next LOAD reinitialises them.
- Unused state encodings -> IDLE on the next edge.

Optional Feature:
FACT_CU_CYCLE_CNT_EN.
- Defined: cycles counts clock edges spent in LOAD, CHECK and MULT.
  - Cleared to 0 on the IDLE->LOAD transition.
  - Increments by 1 each edge while busy=1.
  - Saturates at all-ones (CYC_W bits) and does not wrap.
  - Held in DONE, ERR and IDLE until the next LOAD; ERR leaves the previous value unchanged.
- Undefined: the cycles port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package fact_pkg:
  - state type with encodings IDLE=3'd0, LOAD=3'd1, CHECK=3'd2, MULT=3'd3, DONE=3'd4, ERR=3'd5;
  - constant FACT_MAX_N=12, shared with the datapath's gt_in comparison.
- One sub-module, fact_cyc_cnt: saturating counter with clear/enable, instantiated only under FACT_CU_CYCLE_CNT_EN.
- Next-state logic and output decode stay in fact_cu.

Test Plan:
- Reset: hold rst=0 with go=1 for 3 cycles -> all outputs 0 and state IDLE; release rst with go=1, gt_in=0 -> load_cnt=1 on the next cycle.
- Normal run, n=5 with datapath attached: go=1 -> done=1 after 10 edges, nf=120, en pulses exactly 4 times; drop go -> done=0 and IDLE one edge later.
- Boundary n=0 and n=1: done after 2 edges, nf=1, en never asserted. n=12: done after 24 edges, nf=479001600.
- Error: n=13, go=1 -> err=1 after 1 edge, load_cnt/load_reg never asserted; err held while go=1 and clears one edge after go=0.
- Early go drop: n=4, drop go in the cycle after LOAD -> done=1 for exactly one cycle with nf=24, then IDLE; a fresh go=1 then starts a new run.
- With FACT_CU_CYCLE_CNT_EN and CYC_W=4: n=12 -> cycles saturates at 15 (not 24 mod 16 = 8); next run with n=3 -> cycles=6.
